// File: rtl/ps2_keyboard_fifo.sv
// PS/2 keyboard receiver for the Apple-1 I/O page: frame reception with
// start/parity/stop checking and timeout, Set-2 scan-code decoding with
// shift/ctrl/caps-lock, and a character FIFO read through a data/status
// register pair.
module ps2_keyboard_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 50000,
    parameter int LOWERCASE  = 0
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic       key_clk,
    input  logic       key_din,
    input  logic       cs,
    input  logic       address,
    output logic [7:0] dout
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    // ------------------------------------------------------------------
    // Input synchronisers; idle-high reset values avoid a fake edge.
    // ------------------------------------------------------------------
    logic [1:0] kc_sync_reg;
    logic [1:0] kd_sync_reg;
    logic       kc_prev_reg;
    logic       fall_edge;
    logic       bit_in;

    // Two-stage synchronisers plus one delayed copy for edge detection
    always_ff @(posedge clk25) begin
        if (rst) begin
            kc_sync_reg <= 2'b11;
            kd_sync_reg <= 2'b11;
            kc_prev_reg <= 1'b1;
        end else begin
            kc_sync_reg <= {kc_sync_reg[0], key_clk};
            kd_sync_reg <= {kd_sync_reg[0], key_din};
            kc_prev_reg <= kc_sync_reg[1];
        end
    end

    assign fall_edge = kc_prev_reg & ~kc_sync_reg[1];
    assign bit_in    = kd_sync_reg[1];

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    rx_state_t     rx_state_reg;
    logic [2:0]    bit_cnt_reg;
    logic [7:0]    data_reg;
    logic          parity_ok_reg;
    logic [TW-1:0] tmo_reg;
    logic          byte_valid_reg;
    logic          frame_err_reg;

    // Shift in one bit per falling edge; abort the frame on a stalled clock
    always_ff @(posedge clk25) begin
        if (rst) begin
            rx_state_reg   <= RX_IDLE;
            bit_cnt_reg    <= 3'd0;
            data_reg       <= 8'h00;
            parity_ok_reg  <= 1'b0;
            tmo_reg        <= '0;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            if (fall_edge) begin
                tmo_reg <= '0;
                case (rx_state_reg)
                    RX_IDLE: begin
                        if (!bit_in) begin
                            rx_state_reg <= RX_DATA;
                            bit_cnt_reg  <= 3'd0;
                        end
                    end
                    RX_DATA: begin
                        data_reg    <= {bit_in, data_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            rx_state_reg <= RX_PARITY;
                        end
                    end
                    RX_PARITY: begin
                        parity_ok_reg <= ^{data_reg, bit_in};
                        rx_state_reg  <= RX_STOP;
                    end
                    default: begin
                        rx_state_reg <= RX_IDLE;
                        if (bit_in && parity_ok_reg) begin
                            byte_valid_reg <= 1'b1;
                        end else begin
                            frame_err_reg <= 1'b1;
                        end
                    end
                endcase
            end else if (rx_state_reg != RX_IDLE) begin
                if (tmo_reg == TW'(TIMEOUT)) begin
                    rx_state_reg  <= RX_IDLE;
                    frame_err_reg <= 1'b1;
                    tmo_reg       <= '0;
                end else begin
                    tmo_reg <= tmo_reg + TW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan-code table: {valid, is_letter, unshifted[6:0], shifted[6:0]}
    // Letters carry their uppercase code; case is applied afterwards.
    // ------------------------------------------------------------------
    function automatic logic [15:0] map_code(input logic [7:0] code);
        logic [15:0] m;
        case (code)
            8'h1C: m = {2'b11, 7'h41, 7'h41};
            8'h32: m = {2'b11, 7'h42, 7'h42};
            8'h21: m = {2'b11, 7'h43, 7'h43};
            8'h23: m = {2'b11, 7'h44, 7'h44};
            8'h24: m = {2'b11, 7'h45, 7'h45};
            8'h2B: m = {2'b11, 7'h46, 7'h46};
            8'h34: m = {2'b11, 7'h47, 7'h47};
            8'h33: m = {2'b11, 7'h48, 7'h48};
            8'h43: m = {2'b11, 7'h49, 7'h49};
            8'h3B: m = {2'b11, 7'h4A, 7'h4A};
            8'h42: m = {2'b11, 7'h4B, 7'h4B};
            8'h4B: m = {2'b11, 7'h4C, 7'h4C};
            8'h3A: m = {2'b11, 7'h4D, 7'h4D};
            8'h31: m = {2'b11, 7'h4E, 7'h4E};
            8'h44: m = {2'b11, 7'h4F, 7'h4F};
            8'h4D: m = {2'b11, 7'h50, 7'h50};
            8'h15: m = {2'b11, 7'h51, 7'h51};
            8'h2D: m = {2'b11, 7'h52, 7'h52};
            8'h1B: m = {2'b11, 7'h53, 7'h53};
            8'h2C: m = {2'b11, 7'h54, 7'h54};
            8'h3C: m = {2'b11, 7'h55, 7'h55};
            8'h2A: m = {2'b11, 7'h56, 7'h56};
            8'h1D: m = {2'b11, 7'h57, 7'h57};
            8'h22: m = {2'b11, 7'h58, 7'h58};
            8'h35: m = {2'b11, 7'h59, 7'h59};
            8'h1A: m = {2'b11, 7'h5A, 7'h5A};
            8'h45: m = {2'b10, 7'h30, 7'h29};
            8'h16: m = {2'b10, 7'h31, 7'h21};
            8'h1E: m = {2'b10, 7'h32, 7'h40};
            8'h26: m = {2'b10, 7'h33, 7'h23};
            8'h25: m = {2'b10, 7'h34, 7'h24};
            8'h2E: m = {2'b10, 7'h35, 7'h25};
            8'h36: m = {2'b10, 7'h36, 7'h5E};
            8'h3D: m = {2'b10, 7'h37, 7'h26};
            8'h3E: m = {2'b10, 7'h38, 7'h2A};
            8'h46: m = {2'b10, 7'h39, 7'h28};
            8'h0E: m = {2'b10, 7'h60, 7'h7E};
            8'h4E: m = {2'b10, 7'h2D, 7'h5F};
            8'h55: m = {2'b10, 7'h3D, 7'h2B};
            8'h54: m = {2'b10, 7'h5B, 7'h7B};
            8'h5B: m = {2'b10, 7'h5D, 7'h7D};
            8'h5D: m = {2'b10, 7'h5C, 7'h7C};
            8'h4C: m = {2'b10, 7'h3B, 7'h3A};
            8'h52: m = {2'b10, 7'h27, 7'h22};
            8'h41: m = {2'b10, 7'h2C, 7'h3C};
            8'h49: m = {2'b10, 7'h2E, 7'h3E};
            8'h4A: m = {2'b10, 7'h2F, 7'h3F};
            8'h29: m = {2'b10, 7'h20, 7'h20};
            8'h66: m = {2'b10, 7'h08, 7'h08};
            8'h5A: m = {2'b10, 7'h0D, 7'h0D};
            8'h76: m = {2'b10, 7'h1B, 7'h1B};
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

    // ------------------------------------------------------------------
    // Decoder FSM and modifiers
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {S_NORMAL, S_F0, S_E0, S_E0F0} dec_state_t;

    dec_state_t  dec_state_reg;
    logic        lshift_reg;
    logic        rshift_reg;
    logic        lctrl_reg;
    logic        rctrl_reg;
    logic        caps_reg;
    logic        push_reg;
    logic [6:0]  push_char_reg;
    logic [15:0] map;
    logic [6:0]  make_char;

    // Apply shift / caps-lock / ctrl to the table entry of the current byte
    always_comb begin
        map       = map_code(data_reg);
        make_char = map[13:7];
        if (map[14]) begin
            if (lctrl_reg | rctrl_reg) begin
                make_char = map[13:7] & 7'h1F;
            end else if ((LOWERCASE != 0) && !((lshift_reg | rshift_reg) ^ caps_reg)) begin
                make_char = map[13:7] | 7'h20;
            end
        end else if (lshift_reg | rshift_reg) begin
            make_char = map[6:0];
        end
    end

    // Track prefixes and modifier state; emit a one-cycle push per make code
    always_ff @(posedge clk25) begin
        if (rst) begin
            dec_state_reg <= S_NORMAL;
            lshift_reg    <= 1'b0;
            rshift_reg    <= 1'b0;
            lctrl_reg     <= 1'b0;
            rctrl_reg     <= 1'b0;
            caps_reg      <= 1'b0;
            push_reg      <= 1'b0;
            push_char_reg <= 7'h00;
        end else begin
            push_reg <= 1'b0;
            if (byte_valid_reg) begin
                case (dec_state_reg)
                    S_NORMAL: begin
                        if (data_reg == 8'hF0) begin
                            dec_state_reg <= S_F0;
                        end else if (data_reg == 8'hE0) begin
                            dec_state_reg <= S_E0;
                        end else if (data_reg == 8'h12) begin
                            lshift_reg <= 1'b1;
                        end else if (data_reg == 8'h59) begin
                            rshift_reg <= 1'b1;
                        end else if (data_reg == 8'h14) begin
                            lctrl_reg <= 1'b1;
                        end else if (data_reg == 8'h58) begin
                            caps_reg <= ~caps_reg;
                        end else if (map[15]) begin
                            push_reg      <= 1'b1;
                            push_char_reg <= make_char;
                        end
                    end
                    S_E0: begin
                        if (data_reg == 8'hF0) begin
                            dec_state_reg <= S_E0F0;
                        end else begin
                            dec_state_reg <= S_NORMAL;
                            if (data_reg == 8'h14) begin
                                rctrl_reg <= 1'b1;
                            end else if (data_reg == 8'h5A) begin
                                push_reg      <= 1'b1;
                                push_char_reg <= 7'h0D;
                            end
                        end
                    end
                    S_F0: begin
                        dec_state_reg <= S_NORMAL;
                        if (data_reg == 8'h12) lshift_reg <= 1'b0;
                        if (data_reg == 8'h59) rshift_reg <= 1'b0;
                        if (data_reg == 8'h14) lctrl_reg  <= 1'b0;
                    end
                    default: begin
                        dec_state_reg <= S_NORMAL;
                        if (data_reg == 8'h14) rctrl_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Character FIFO and CPU register interface
    // ------------------------------------------------------------------
    logic [6:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          ovf_reg;
    logic          ferr_reg;
    logic [7:0]    dout_reg;
    logic          empty;
    logic          full;
    logic          rd_data;
    logic          rd_stat;
    logic          pop;
    logic          push_ok;
    logic          ovf_set;
    logic [6:0]    count_ext;
    logic [3:0]    count_sat;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CW'(FIFO_DEPTH));
    assign rd_data   = cs & ~address;
    assign rd_stat   = cs & address;
    assign pop       = rd_data & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push_ok   = push_reg & (~full | pop);
    assign ovf_set   = push_reg & full & ~pop;
    assign count_ext = 7'(count_reg);
    assign count_sat = (count_ext > 7'd15) ? 4'hF : count_ext[3:0];

    // Storage write port
    always_ff @(posedge clk25) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_char_reg;
        end
    end

    // Pointers, occupancy, sticky flags and registered read data
    always_ff @(posedge clk25) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
            ferr_reg   <= 1'b0;
            dout_reg   <= 8'h00;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)     rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            ovf_reg  <= (ovf_reg  & ~rd_stat) | ovf_set;
            ferr_reg <= (ferr_reg & ~rd_stat) | frame_err_reg;
            if (rd_data) begin
                dout_reg <= empty ? 8'h00 : {1'b1, mem[rd_ptr_reg]};
            end else if (rd_stat) begin
                dout_reg <= {~empty, ovf_reg, ferr_reg, 1'b0, count_sat};
            end
        end
    end

    assign dout = dout_reg;

endmodule

// File: tb/tb_ps2_keyboard_fifo.sv
// Scoreboard bench for ps2_keyboard_fifo: PS/2 frames are bit-banged,
// each CPU read pushes its hand-computed expected byte, and a monitor
// compares dout on the cycle after every strobe.
module tb_ps2_keyboard_fifo;

    localparam int DEPTH = 8;
    localparam int TMO   = 200;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       key_clk = 1'b1;
    logic       key_din = 1'b1;
    logic       cs      = 1'b0;
    logic       cs_lc   = 1'b0;
    logic       address = 1'b0;
    logic [7:0] dout;
    logic [7:0] dout_lc;

    always #20 clk = ~clk;

    ps2_keyboard_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO), .LOWERCASE(0)) dut (
        .clk25(clk), .rst(rst), .key_clk(key_clk), .key_din(key_din),
        .cs(cs), .address(address), .dout(dout)
    );

    ps2_keyboard_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO), .LOWERCASE(1)) dut_lc (
        .clk25(clk), .rst(rst), .key_clk(key_clk), .key_din(key_din),
        .cs(cs_lc), .address(address), .dout(dout_lc)
    );

    // Scoreboard
    logic [7:0] exp_q[$];
    string      name_q[$];
    logic [7:0] exp_lc_q[$];
    string      name_lc_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       rd_seen = 1'b0;
    logic       rd_lc_seen = 1'b0;
    logic [7:0] e_val;
    string      e_nm;

    always @(posedge clk) begin
        rd_seen    <= cs;
        rd_lc_seen <= cs_lc;
    end

    // Monitor: dout is valid the cycle after a strobe
    always @(negedge clk) begin
        if (rd_seen) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_read: dout=%02h with no expected value", dout);
            end else begin
                e_val = exp_q.pop_front();
                e_nm  = name_q.pop_front();
                if (dout !== e_val) begin
                    n_bad++;
                    $display("FAIL %s: dout=%02h expected=%02h", e_nm, dout, e_val);
                end else begin
                    $display("ok   %s: dout=%02h", e_nm, dout);
                end
            end
        end
        if (rd_lc_seen) begin
            n_cmp++;
            if (exp_lc_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_read_lc: dout=%02h with no expected value", dout_lc);
            end else begin
                e_val = exp_lc_q.pop_front();
                e_nm  = name_lc_q.pop_front();
                if (dout_lc !== e_val) begin
                    n_bad++;
                    $display("FAIL %s: dout=%02h expected=%02h", e_nm, dout_lc, e_val);
                end else begin
                    $display("ok   %s: dout=%02h", e_nm, dout_lc);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One CPU access; lc selects the LOWERCASE=1 instance
    task automatic rd(input bit lc, input bit a, input logic [7:0] e, input string nm);
        @(negedge clk);
        address = a;
        if (lc) begin
            cs_lc = 1'b1;
            exp_lc_q.push_back(e);
            name_lc_q.push_back(nm);
        end else begin
            cs = 1'b1;
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        @(negedge clk);
        cs    = 1'b0;
        cs_lc = 1'b0;
    endtask

    // Full PS/2 frame; rd_at_stop strobes a data read exactly when the
    // resulting character is pushed (4 negedges after the stop-bit fall).
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit rd_at_stop);
        logic [10:0] bits;
        logic        p;
        p = ~^b;
        if (bad_par) p = ~p;
        bits = {1'b1, p, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            key_din = bits[i];
            idle(10);
            key_clk = 1'b0;
            if (i == 10 && rd_at_stop) begin
                idle(4);
                address = 1'b0;
                cs = 1'b1;
                exp_q.push_back(8'hC1);
                name_q.push_back("full_rd_with_push");
                idle(1);
                cs = 1'b0;
                idle(15);
            end else begin
                idle(20);
            end
            key_clk = 1'b1;
            idle(10);
        end
        key_din = 1'b1;
        idle(10);
    endtask

    task automatic key(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0);
    endtask

    // Start bit plus (n-1) data bits, then clock left idle
    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) begin
            key_din = (i == 0) ? 1'b0 : 1'b1;
            idle(10);
            key_clk = 1'b0;
            idle(20);
            key_clk = 1'b1;
            idle(10);
        end
        key_din = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        idle(4);
        rst = 1'b0;
        idle(2);

        rd(0, 1, 8'h00, "reset_status");
        rd(0, 0, 8'h00, "reset_data_empty");
        rd(1, 1, 8'h00, "lc_reset_status");

        // caps-lock on the lowercase instance
        key(8'h58); key(8'h1C);
        rd(1, 0, 8'hC1, "lc_caps_on_A");
        key(8'h58); key(8'h1C);
        rd(1, 0, 8'hE1, "lc_caps_off_a");

        // the uppercase instance saw the same two 'A's
        rd(0, 0, 8'hC1, "A_first");
        rd(0, 0, 8'hC1, "A_second");
        rd(0, 1, 8'h00, "status_after_A");

        // shift make/release
        key(8'h12); key(8'h1E); key(8'hF0); key(8'h12); key(8'h1E);
        rd(0, 0, 8'hC0, "shift_2_is_at");
        rd(0, 0, 8'hB2, "plain_2");

        // parity error
        send_frame(8'h1C, 1'b1, 1'b0);
        rd(0, 1, 8'h20, "parity_err_status");
        rd(0, 1, 8'h00, "parity_err_cleared");

        // timeout mid-frame, then recovery
        send_partial(4);
        idle(2 * TMO);
        rd(0, 1, 8'h20, "timeout_status");
        key(8'h32);
        rd(0, 0, 8'hC2, "after_timeout_B");
        rd(0, 1, 8'h00, "status_clean");

        // overflow
        repeat (DEPTH + 1) key(8'h1C);
        rd(0, 1, 8'hC8, "overflow_status");
        for (int i = 0; i < DEPTH; i++) rd(0, 0, 8'hC1, "drain_A");
        rd(0, 0, 8'h00, "drained_empty");
        rd(0, 1, 8'h00, "status_empty");

        // pointer wrap
        key(8'h1C); key(8'h32); key(8'h21);
        rd(0, 0, 8'hC1, "wrap_A");
        rd(0, 0, 8'hC2, "wrap_B");
        rd(0, 0, 8'hC3, "wrap_C");

        // full FIFO: read and push in the same cycle
        repeat (DEPTH) key(8'h1C);
        send_frame(8'h32, 1'b0, 1'b1);
        rd(0, 1, 8'h88, "full_rdpush_status");
        for (int i = 0; i < DEPTH - 1; i++) rd(0, 0, 8'hC1, "full_drain_A");
        rd(0, 0, 8'hC2, "full_drain_B");
        rd(0, 1, 8'h00, "full_status_end");

        // reset in the middle of a frame
        send_partial(5);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);
        rd(0, 1, 8'h00, "post_reset_status");
        key(8'h1C);
        rd(0, 0, 8'hC1, "post_reset_A");

        idle(5);
        n_cmp++;
        if (exp_q.size() != 0 || exp_lc_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_reads: %0d/%0d expected values never compared",
                     exp_q.size(), exp_lc_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_fifo.md
# ps2_keyboard_fifo

Parametrised PS/2 keyboard receiver and scan-code translator for the Apple-1 I/O page. It oversamples the keyboard clock and data lines in the `clk25` domain and checks start, parity and stop bits. Set-2 scan codes are translated to 7-bit ASCII with shift, caps-lock and ctrl handling. Characters are queued in a FIFO that the CPU reads through a two-register interface (data and status).

## Interface
Parameters:
- `FIFO_DEPTH`, 8: character FIFO entries; must be a power of 2, 2..64.
- `TIMEOUT`, 50000: `clk25` cycles allowed between `key_clk` falling edges inside a frame (2 ms).
- `LOWERCASE`, 0: 0 = letters always uppercase (Apple-1 mode); 1 = letters lowercase unless shift XOR caps-lock.

Ports:
- `clk25` in 1: 25 MHz system clock. Single clock; all logic is synchronous to it.
- `rst` in 1: reset. Synchronous, active-high.
- `key_clk` in 1: PS/2 clock from the keyboard. Asynchronous.
- `key_din` in 1: PS/2 data from the keyboard. Asynchronous.
- `cs` in 1: chip select. One-cycle strobe per CPU access.
- `address` in 1: 0 = RX data (pops the FIFO); 1 = RX status (clears the sticky flags).
- `dout` out 8: registered read data.

## Operation
- **Input synchronisation.** `key_clk` and `key_din` each pass through 2 flip-flops. A falling edge of the synchronised clock is one event; data is sampled on that event.
- **Frame FSM.**
  - States: RX_IDLE → RX_DATA (8 bits, LSB first) → RX_PARITY → RX_STOP → RX_IDLE.
  - In RX_IDLE, a sampled 1 is ignored; a sampled 0 (start bit) enters RX_DATA with the bit count at 0.
  - Parity is odd over the 8 data bits plus the parity bit.
  - Parity error, or stop bit = 0: the byte is dropped and `ferr` is set.
  - Timeout: outside RX_IDLE, if more than `TIMEOUT` cycles pass without an edge, the FSM returns to RX_IDLE, `ferr` is set and the byte is dropped. The timeout counter restarts on every edge.
- **Decoder FSM.**
  - States: S_NORMAL, S_F0, S_E0, S_E0F0.
  - S_NORMAL: F0 → S_F0; E0 → S_E0; any other code is a make code.
  - S_E0: F0 → S_E0F0; any other code is an extended make code, then → S_NORMAL.
  - S_F0 and S_E0F0: the code is a release code, then → S_NORMAL.
- **Modifiers.**
  - Shift: 12 and 59 are tracked as separate bits; shift = OR of the two.
  - Ctrl: 14 and E0 14 are tracked as separate bits.
  - Caps-lock: 58 toggles on each make code; its release is ignored.
  - Modifier codes never push a character.
- **Translation.**
  - US layout: letters, digits, punctuation and their shifted symbols.
  - Special keys: 29 → 0x20 (space), 66 → 0x08 (backspace), 5A → 0x0D (enter), E0 5A → 0x0D, 76 → 0x1B (escape).
  - Ctrl + letter produces uppercase ASCII AND 0x1F.
  - Unmapped codes, release codes and other extended codes push nothing.
  - Typematic repeats push again.
- **FIFO.**
  - Entries are 7 bits wide; `count` is 0..`FIFO_DEPTH`.
  - Push when full: the new character is dropped and `ovf` is set.
  - Push and pop in the same cycle: both take effect and `count` is unchanged. When full, no overflow occurs. When empty, the read returns 0x00 and the pushed character is stored.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Data read** (`cs`=1, `address`=0):
  - FIFO not empty: `dout` = {1, head}, then pop.
  - FIFO empty: `dout` = 0x00 and nothing is popped.
- **Status read** (`cs`=1, `address`=1):
  - `dout` = {nonempty, `ovf`, `ferr`, 0, min(`count`, 15)[3:0]}.
  - `ovf` and `ferr` are cleared after the read. If a new error event occurs in the same cycle, that flag stays set.
- **Idle bus.** When `cs`=0, `dout` holds its value.
- **Reset.**
  - `dout` = 0x00; FIFO empty; `ovf`, `ferr`, shift, ctrl and caps cleared.
  - Both FSMs go to their idle states and the timeout counter is cleared.
  - Reset mid-frame discards the partial byte. Resynchronisation occurs at the next start bit.

## Timing
- The falling-edge event is detected 3 `clk25` cycles after the pin falls.
- A completed byte reaches the decoder 1 cycle after the stop-bit event.
- A character is visible in status ≤ 6 cycles after the stop-bit pin edge.
- `dout` is valid on the cycle after the `cs` strobe.
- Back-to-back `cs` strobes are supported, one access per cycle.
- The minimum PS/2 bit period is 60 µs. The receiver must tolerate clock high/low phases ≥ 10 `clk25` cycles.

## Test plan
- Reset, then status read → 0x00. Data read → 0x00.
- Frame 1C (parity 0, stop 1), then data read → 0xC1 ('A'). A following status read → 0x00.
- Send 12, 1E, F0 12, 1E, then read 2 bytes → 0xC0 ('@'), 0xB2 ('2').
  - Caps-lock toggle with `LOWERCASE`=1: 58, 1C → 0xC1; 58, 1C → 0xE1.
- Frame 1C with bad parity → no push; status read → 0x20, then 0x00 on the next read.
  - Start bit followed by 3 bits then silence > `TIMEOUT` → `ferr` set. A following valid 32 → 0xC2 ('B').
- Push `FIFO_DEPTH`+1 'A' characters with no reads → status reads {1,1,0,0,min(`FIFO_DEPTH`,15)}.
  - Drain `FIFO_DEPTH` reads of 0xC1, then 0x00. Wrap is verified by a further 3 characters read back in order.
- Full FIFO: a data read in the same cycle as a decoder push → no `ovf`, `count` unchanged.
  - Assert `rst` mid-frame → next full frame decodes correctly.
